// File: rtl/hazard_pkg.sv
// Shared constants and decode helpers for the MIPS pipeline hazard controller.
// State encodings are kept as plain 2-bit constants so HzState maps directly onto them.
package hazard_pkg;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic       valid;
        logic [4:0] rnum;
    } sb_slot_t;

    function automatic logic uses_rs(input logic [5:0] op);
        return !((op == OP_J) || (op == OP_JAL));
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
// Counter width must match the CNT_W of the controller attached to it.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      ID_Instr;
    logic             ID_RegWrite;
    logic             ID_RegDst;
    logic             ID_Jump;
    logic             MEM_PCSrc;
    logic             PCWrite;
    logic             IFID_Write;
    logic             IFID_Flush;
    logic             IDEX_Bubble;
    logic             EXMEM_Flush;
    logic [1:0]       HzState;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushEvents;

    modport master (
        output ID_Instr, ID_RegWrite, ID_RegDst, ID_Jump, MEM_PCSrc,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Flush,
        input  HzState, StallCycles, FlushEvents
    );

    modport slave (
        input  ID_Instr, ID_RegWrite, ID_RegDst, ID_Jump, MEM_PCSrc,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Flush,
        output HzState, StallCycles, FlushEvents
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Three-slot in-flight destination tracker (EX, MEM, WB) with RAW comparators.
// Slot 0 = EX, 1 = MEM, 2 = WB; the WB slot is masked out when the RF writes first.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter bit RF_WRITE_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        clear_i,
    input  logic        squash_i,
    input  logic        advance_i,
    input  logic [31:0] instr_i,
    input  logic        reg_write_i,
    input  logic        reg_dst_i,
    output logic        hazard_o
);

    localparam logic [2:0] CHECK_MASK = RF_WRITE_FIRST ? 3'b011 : 3'b111;

    sb_slot_t [2:0] slot_q;
    sb_slot_t [2:0] slot_d;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] dest;
    logic       rs_used;
    logic       rt_used;
    logic [2:0] slot_hit;
    logic       unused_funct;

    assign opcode       = instr_i[31:26];
    assign rs           = instr_i[25:21];
    assign rt           = instr_i[20:16];
    assign rd           = instr_i[15:11];
    assign dest         = reg_dst_i ? rd : rt;
    assign unused_funct = ^instr_i[10:0];

    // $0 is hard-wired, so reading it can never depend on an in-flight write.
    assign rs_used = uses_rs(opcode) && (rs != 5'd0);
    assign rt_used = uses_rt(opcode) && (rt != 5'd0);

    for (genvar gi = 0; gi < 3; gi++) begin : g_cmp
        assign slot_hit[gi] = CHECK_MASK[gi] && slot_q[gi].valid &&
                              ((rs_used && (slot_q[gi].rnum == rs)) ||
                               (rt_used && (slot_q[gi].rnum == rt)));
    end

    assign hazard_o = |slot_hit;

    always_comb begin
        slot_d[2] = slot_q[1];
        slot_d[1] = slot_q[0];
        slot_d[0] = '0;
        if (squash_i) begin
            // The EX-stage instruction is on the wrong path and never reaches MEM.
            slot_d[1] = '0;
        end else if (advance_i && reg_write_i && (dest != 5'd0)) begin
            slot_d[0].valid = 1'b1;
            slot_d[0].rnum  = dest;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline without forwarding.
// Outputs are combinational from the current state and the current ID/MEM inputs.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter bit RF_WRITE_FIRST = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    logic hazard;
    logic sb_clear;
    logic advance;
    logic squash;
    logic count_stall;
    logic count_flush;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_flush;

    assign sb_clear = !Rst_n || (state_q == ST_INIT);

    hazard_scoreboard #(
        .RF_WRITE_FIRST(RF_WRITE_FIRST)
    ) u_sb (
        .clk        (Clk),
        .clear_i    (sb_clear),
        .squash_i   (squash),
        .advance_i  (advance),
        .instr_i    (bus.ID_Instr),
        .reg_write_i(bus.ID_RegWrite),
        .reg_dst_i  (bus.ID_RegDst),
        .hazard_o   (hazard)
    );

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        advance     = 1'b0;
        squash      = 1'b0;
        count_stall = 1'b0;
        count_flush = 1'b0;
        if (state_q == ST_INIT) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_d     = ST_RUN;
        end else if (bus.MEM_PCSrc) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            squash      = 1'b1;
            count_flush = 1'b1;
            state_d     = ST_FLUSH;
        end else if (hazard && (state_q != ST_FLUSH)) begin
            // ID holds a NOP right after a flush, so its hazard result is ignored there.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            count_stall = 1'b1;
            state_d     = ST_STALL;
        end else begin
            advance = 1'b1;
            state_d = ST_RUN;
            if (bus.ID_Jump) begin
                ifid_flush  = 1'b1;
                count_flush = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (count_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (count_flush && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= ST_INIT;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.IFID_Write  = ifid_write;
    assign bus.IFID_Flush  = ifid_flush;
    assign bus.IDEX_Bubble = idex_bubble;
    assign bus.EXMEM_Flush = exmem_flush;
    assign bus.HzState     = state_q;
    assign bus.StallCycles = stall_cnt_q;
    assign bus.FlushEvents = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three instances (write-first, write-second, 2-bit counters)
// share one stimulus stream; expected records are queued when driven and popped when sampled.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    localparam logic [31:0] I_ADD3  = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] I_SUB5  = 32'h0064_2822; // sub  $5,$3,$4
    localparam logic [31:0] I_ADDI0 = 32'h2000_0005; // addi $0,$0,5
    localparam logic [31:0] I_ADD6  = 32'h0000_3020; // add  $6,$0,$0
    localparam logic [31:0] I_ADD7  = 32'h0022_3820; // add  $7,$1,$2
    localparam logic [31:0] I_J100  = 32'h0800_0040; // j    0x100
    localparam logic [31:0] I_ADD8  = 32'h00E0_4020; // add  $8,$7,$0
    localparam logic [31:0] I_ADD9  = 32'h0100_4820; // add  $9,$8,$0

    // {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Flush}
    localparam logic [4:0] C_INIT  = 5'b00111;
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00010;
    localparam logic [4:0] C_BR    = 5'b11111;
    localparam logic [4:0] C_JMP   = 5'b11100;

    localparam int C_SAT = 3;

    typedef struct {
        logic        rst_n;
        logic [31:0] instr;
        logic        rw;
        logic        rdst;
        logic        jmp;
        logic        pcs;
        logic [1:0]  st_a;
        logic [4:0]  ctl_a;
        int          stall_a;
        logic [1:0]  st_b;
        logic [4:0]  ctl_b;
        int          stall_b;
        int          flush;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
    pipeline_hazard_ctrl_if #(.CNT_W(16)) bus_b ();
    pipeline_hazard_ctrl_if #(.CNT_W(2))  bus_c ();

    pipeline_hazard_ctrl #(.RF_WRITE_FIRST(1'b1), .CNT_W(16)) dut_a (
        .Clk(clk), .Rst_n(rst_n), .bus(bus_a)
    );
    pipeline_hazard_ctrl #(.RF_WRITE_FIRST(1'b0), .CNT_W(16)) dut_b (
        .Clk(clk), .Rst_n(rst_n), .bus(bus_b)
    );
    pipeline_hazard_ctrl #(.RF_WRITE_FIRST(1'b0), .CNT_W(2)) dut_c (
        .Clk(clk), .Rst_n(rst_n), .bus(bus_c)
    );

    logic [4:0]  ctl_act   [3];
    logic [1:0]  st_act    [3];
    logic [31:0] stall_act [3];
    logic [31:0] flush_act [3];

    assign ctl_act[0]   = {bus_a.PCWrite, bus_a.IFID_Write, bus_a.IFID_Flush, bus_a.IDEX_Bubble, bus_a.EXMEM_Flush};
    assign ctl_act[1]   = {bus_b.PCWrite, bus_b.IFID_Write, bus_b.IFID_Flush, bus_b.IDEX_Bubble, bus_b.EXMEM_Flush};
    assign ctl_act[2]   = {bus_c.PCWrite, bus_c.IFID_Write, bus_c.IFID_Flush, bus_c.IDEX_Bubble, bus_c.EXMEM_Flush};
    assign st_act[0]    = bus_a.HzState;
    assign st_act[1]    = bus_b.HzState;
    assign st_act[2]    = bus_c.HzState;
    assign stall_act[0] = 32'(bus_a.StallCycles);
    assign stall_act[1] = 32'(bus_b.StallCycles);
    assign stall_act[2] = 32'(bus_c.StallCycles);
    assign flush_act[0] = 32'(bus_a.FlushEvents);
    assign flush_act[1] = 32'(bus_b.FlushEvents);
    assign flush_act[2] = 32'(bus_c.FlushEvents);

    int   errors = 0;
    int   checks = 0;
    int   row    = 0;
    vec_t exp_q[$];
    vec_t tbl[26];

    function automatic vec_t mk(input logic r, input logic [31:0] ins, input logic rw, input logic rdst,
                                input logic jmp, input logic pcs,
                                input logic [1:0] sa, input logic [4:0] ca, input int ta,
                                input logic [1:0] sb, input logic [4:0] cb, input int tb, input int fl);
        vec_t v;
        v.rst_n = r;  v.instr = ins; v.rw = rw; v.rdst = rdst; v.jmp = jmp; v.pcs = pcs;
        v.st_a = sa;  v.ctl_a = ca;  v.stall_a = ta;
        v.st_b = sb;  v.ctl_b = cb;  v.stall_b = tb;
        v.flush = fl;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL row%0d %s: got %0d expected %0d", row, name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n             = v.rst_n;
        bus_a.ID_Instr    = v.instr; bus_b.ID_Instr    = v.instr; bus_c.ID_Instr    = v.instr;
        bus_a.ID_RegWrite = v.rw;    bus_b.ID_RegWrite = v.rw;    bus_c.ID_RegWrite = v.rw;
        bus_a.ID_RegDst   = v.rdst;  bus_b.ID_RegDst   = v.rdst;  bus_c.ID_RegDst   = v.rdst;
        bus_a.ID_Jump     = v.jmp;   bus_b.ID_Jump     = v.jmp;   bus_c.ID_Jump     = v.jmp;
        bus_a.MEM_PCSrc   = v.pcs;   bus_b.MEM_PCSrc   = v.pcs;   bus_c.MEM_PCSrc   = v.pcs;
    endtask

    task automatic check_front();
        vec_t e;
        int   st_req, ctl_req, stall_req, flush_req;
        e = exp_q.pop_front();
        for (int d = 0; d < 3; d++) begin
            st_req    = (d == 0) ? int'(e.st_a)  : int'(e.st_b);
            ctl_req   = (d == 0) ? int'(e.ctl_a) : int'(e.ctl_b);
            stall_req = (d == 0) ? e.stall_a : e.stall_b;
            flush_req = e.flush;
            if (d == 2) begin
                stall_req = (stall_req > C_SAT) ? C_SAT : stall_req;
                flush_req = (flush_req > C_SAT) ? C_SAT : flush_req;
            end
            chk($sformatf("dut%0d HzState", d),     int'(st_act[d]),  st_req);
            chk($sformatf("dut%0d ctrl", d),        int'(ctl_act[d]), ctl_req);
            chk($sformatf("dut%0d StallCycles", d), int'(stall_act[d]), stall_req);
            chk($sformatf("dut%0d FlushEvents", d), int'(flush_act[d]), flush_req);
        end
        $display("row %0d instr=%08h pcs=%0d st=%0d/%0d/%0d ctl=%05b/%05b/%05b stall=%0d/%0d/%0d flush=%0d/%0d/%0d",
                 row, e.instr, e.pcs, st_act[0], st_act[1], st_act[2], ctl_act[0], ctl_act[1], ctl_act[2],
                 stall_act[0], stall_act[1], stall_act[2], flush_act[0], flush_act[1], flush_act[2]);
    endtask

    task automatic apply(input vec_t v);
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        check_front();
        row++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        // reset, RAW stall, $0 writes, taken branch, jump, reset mid-stall
        tbl[0]  = mk(0, NOP,     0, 0, 0, 0, ST_INIT,  C_INIT,  0, ST_INIT,  C_INIT,  0, 0);
        tbl[1]  = mk(0, NOP,     0, 0, 0, 0, ST_INIT,  C_INIT,  0, ST_INIT,  C_INIT,  0, 0);
        tbl[2]  = mk(1, NOP,     0, 0, 0, 0, ST_INIT,  C_INIT,  0, ST_INIT,  C_INIT,  0, 0);
        tbl[3]  = mk(1, NOP,     0, 0, 0, 0, ST_RUN,   C_RUN,   0, ST_RUN,   C_RUN,   0, 0);
        tbl[4]  = mk(1, I_ADD3,  1, 1, 0, 0, ST_RUN,   C_RUN,   0, ST_RUN,   C_RUN,   0, 0);
        tbl[5]  = mk(1, I_SUB5,  1, 1, 0, 0, ST_RUN,   C_STALL, 0, ST_RUN,   C_STALL, 0, 0);
        tbl[6]  = mk(1, I_SUB5,  1, 1, 0, 0, ST_STALL, C_STALL, 1, ST_STALL, C_STALL, 1, 0);
        tbl[7]  = mk(1, I_SUB5,  1, 1, 0, 0, ST_STALL, C_RUN,   2, ST_STALL, C_STALL, 2, 0);
        tbl[8]  = mk(1, I_SUB5,  1, 1, 0, 0, ST_RUN,   C_RUN,   2, ST_STALL, C_RUN,   3, 0);
        tbl[9]  = mk(1, I_ADDI0, 1, 0, 0, 0, ST_RUN,   C_RUN,   2, ST_RUN,   C_RUN,   3, 0);
        tbl[10] = mk(1, I_ADD6,  1, 1, 0, 0, ST_RUN,   C_RUN,   2, ST_RUN,   C_RUN,   3, 0);
        tbl[11] = mk(1, NOP,     0, 0, 0, 0, ST_RUN,   C_RUN,   2, ST_RUN,   C_RUN,   3, 0);
        tbl[12] = mk(1, NOP,     0, 0, 0, 0, ST_RUN,   C_RUN,   2, ST_RUN,   C_RUN,   3, 0);
        tbl[13] = mk(1, I_ADD3,  1, 1, 0, 0, ST_RUN,   C_RUN,   2, ST_RUN,   C_RUN,   3, 0);
        tbl[14] = mk(1, I_SUB5,  1, 1, 0, 1, ST_RUN,   C_BR,    2, ST_RUN,   C_BR,    3, 0);
        tbl[15] = mk(1, NOP,     0, 0, 0, 0, ST_FLUSH, C_RUN,   2, ST_FLUSH, C_RUN,   3, 1);
        tbl[16] = mk(1, NOP,     0, 0, 0, 0, ST_RUN,   C_RUN,   2, ST_RUN,   C_RUN,   3, 1);
        tbl[17] = mk(1, I_ADD7,  1, 1, 0, 0, ST_RUN,   C_RUN,   2, ST_RUN,   C_RUN,   3, 1);
        tbl[18] = mk(1, I_J100,  0, 0, 1, 0, ST_RUN,   C_JMP,   2, ST_RUN,   C_JMP,   3, 1);
        tbl[19] = mk(1, I_ADD8,  1, 1, 0, 0, ST_RUN,   C_STALL, 2, ST_RUN,   C_STALL, 3, 2);
        tbl[20] = mk(1, I_ADD8,  1, 1, 0, 0, ST_STALL, C_RUN,   3, ST_STALL, C_STALL, 4, 2);
        tbl[21] = mk(1, I_ADD8,  1, 1, 0, 0, ST_RUN,   C_RUN,   3, ST_STALL, C_RUN,   5, 2);
        tbl[22] = mk(1, I_ADD9,  1, 1, 0, 0, ST_RUN,   C_STALL, 3, ST_RUN,   C_STALL, 5, 2);
        tbl[23] = mk(0, I_ADD9,  1, 1, 0, 0, ST_STALL, C_STALL, 4, ST_STALL, C_STALL, 6, 2);
        tbl[24] = mk(1, NOP,     0, 0, 0, 0, ST_INIT,  C_INIT,  0, ST_INIT,  C_INIT,  0, 0);
        tbl[25] = mk(1, I_ADD9,  1, 1, 0, 0, ST_RUN,   C_RUN,   0, ST_RUN,   C_RUN,   0, 0);

        rst_n = 1'b0;
        drive(tbl[0]);
        @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i]);
        end

        // A producer left in the WB slot by a branch must not stall the FLUSH cycle.
        apply(mk(1, I_ADD3, 1, 1, 0, 0, ST_RUN,   C_RUN, 0, ST_RUN,   C_RUN, 0, 0));
        apply(mk(1, NOP,    0, 0, 0, 0, ST_RUN,   C_RUN, 0, ST_RUN,   C_RUN, 0, 0));
        apply(mk(1, NOP,    0, 0, 0, 1, ST_RUN,   C_BR,  0, ST_RUN,   C_BR,  0, 0));
        apply(mk(1, I_SUB5, 1, 1, 0, 0, ST_FLUSH, C_RUN, 0, ST_FLUSH, C_RUN, 0, 1));
        apply(mk(1, I_SUB5, 1, 1, 0, 0, ST_RUN,   C_RUN, 0, ST_RUN,   C_RUN, 0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
